// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed four-digit seven-segment scanner.
//
// Drives one shared active-low segment bus and four active-low digit enables
// from four 8-bit segment patterns. All four patterns and the digit mask are
// captured once per frame, so a refresh never shows a mix of old and new values.
//
// Optional feature macro: DISP_BLANK_EN
//   Defined   : the first BLANK_CYC cycles of every slot are forced blank.
//   Undefined : every slot drives its digit for all CLK_DIV cycles.

module seg_scan_driver #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] LED0,
  input  logic [7:0] LED1,
  input  logic [7:0] LED2,
  input  logic [7:0] LED3,
  input  logic [3:0] dig_mask,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  // Reject illegal configurations at elaboration.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("seg_scan_driver: CLK_DIV must be at least 2");
  end
  if (BLANK_CYC >= CLK_DIV) begin : g_bad_blank_cyc
    $error("seg_scan_driver: BLANK_CYC must be smaller than CLK_DIV");
  end

  // Scan state.
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  // Frame snapshot.
  logic [7:0]       r_sh [4];
  logic [3:0]       r_shmask;

  // Registered outputs.
  logic [7:0]       r_seg;
  logic [3:0]       r_an;
  logic [1:0]       r_digit_idx;
  logic             r_frame_done;

  // Combinational next-state terms.
  logic             w_cnt_last;
  logic             w_snap;
  logic [7:0]       w_live [4];
  logic [7:0]       w_data [4];
  logic [3:0]       w_mask;
  logic             w_dead;
  logic             w_blank;
  logic [7:0]       w_seg_d;
  logic [3:0]       w_an_d;
  logic             w_frame_end;

  // Dead-time window at the start of each slot (only when the feature is built).
`ifdef DISP_BLANK_EN
  if (BLANK_CYC == 0) begin : g_no_dead
    assign w_dead = 1'b0;
  end else begin : g_dead
    assign w_dead = (32'(r_cnt) < BLANK_CYC);
  end
`else
  assign w_dead = 1'b0;
`endif

  // Slot/frame decode, snapshot bypass and next output values.
  always_comb begin
    w_live[0] = LED0;
    w_live[1] = LED1;
    w_live[2] = LED2;
    w_live[3] = LED3;

    w_cnt_last  = (r_cnt == CNT_LAST);
    w_snap      = en && (r_cnt == '0) && (r_idx == 2'd0);
    w_frame_end = en && (r_idx == 2'd3) && w_cnt_last;

    // On a snapshot cycle the shadow still holds last frame's data, so show the
    // live inputs directly; otherwise slot 0 would open with one stale cycle.
    for (int i = 0; i < 4; i++) begin
      w_data[i] = w_snap ? w_live[i] : r_sh[i];
    end
    w_mask = w_snap ? dig_mask : r_shmask;

    w_blank = !en || w_mask[r_idx] || w_dead;

    if (w_blank) begin
      w_an_d  = 4'b1111;
      w_seg_d = 8'hFF;
    end else begin
      w_an_d  = ~(4'b0001 << r_idx);
      w_seg_d = w_data[r_idx];
    end
  end

  // Prescaler and slot index; both freeze while en is low.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (en) begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Frame snapshot of all patterns and the mask at the start of slot 0.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 4; i++) begin
        r_sh[i] <= 8'hFF;
      end
      r_shmask <= 4'b1111;
    end else if (w_snap) begin
      for (int i = 0; i < 4; i++) begin
        r_sh[i] <= w_live[i];
      end
      r_shmask <= dig_mask;
    end
  end

  // Output registers: an and seg change on the same edge, so an enable is
  // never low while the bus carries another digit's pattern.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_an         <= 4'b1111;
      r_seg        <= 8'hFF;
      r_digit_idx  <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_d;
      r_seg        <= w_seg_d;
      r_digit_idx  <= r_idx;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule
